operand_sel_reg: RTL and testbench

//  Parametrised N:1 operand selector feeding a registered, flow-controlled output stage.

---
 rtl/operand_sel_reg_pkg.sv | 23 ++
 rtl/operand_sel_reg_mux_n.sv | 32 +++
 rtl/operand_sel_reg.sv | 120 ++++++++++++
 tb/tb_operand_sel_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_sel_reg_pkg.sv
// ============================================================================
// operand_sel_reg_pkg
//   Shared state encoding and default sizing for the operand selector stage.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package operand_sel_reg_pkg;

    localparam int c_DEFAULT_WIDTH   = 32;
    localparam int c_DEFAULT_NUM_SRC = 4;
    localparam int c_DEFAULT_SEL_W   = 2;

    // Encoding 2'd3 is unused and recovers to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/operand_sel_reg_mux_n.sv
// ============================================================================
// mux_n
//   Flattened N:1 mux; out-of-range codes yield zero and raise a flag.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mux_n #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [NUM_SRC*WIDTH-1:0] i_src_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_out_of_range
);

    always_comb begin
        o_data         = '0;
        o_out_of_range = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data         = i_src_data[k*WIDTH +: WIDTH];
                o_out_of_range = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/operand_sel_reg.sv
// ============================================================================
// operand_sel_reg
//   N:1 operand selector feeding a 2-entry registered skid buffer.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module operand_sel_reg
    import operand_sel_reg_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int NUM_SRC = c_DEFAULT_NUM_SRC,
    parameter int SEL_W   = c_DEFAULT_SEL_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         seletor,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     bad_sel
);

    state_t             r_state;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_head_data;
    logic [SEL_W-1:0]   r_head_src;
    logic [WIDTH-1:0]   r_skid_data;
    logic [SEL_W-1:0]   r_skid_src;
    logic               r_bad_sel;

    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_bad;
    logic               w_accept;
    logic               w_pop;
    logic               w_out_valid;

    mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .i_sel          (seletor),
        .i_src_data     (src_data),
        .o_data         (w_sel_data),
        .o_out_of_range (w_sel_bad)
    );

    assign w_out_valid = (r_state == ST_ONE) || (r_state == ST_TWO);
    assign w_accept    = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_head_data <= '0;
            r_head_src  <= '0;
            r_skid_data <= '0;
            r_skid_src  <= '0;
            r_bad_sel   <= 1'b0;
        end else if (flush) begin
            // Flush wins: the offered beat is dropped and cannot set bad_sel.
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            if (w_accept && w_sel_bad) begin
                r_bad_sel <= 1'b1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head_data <= w_sel_data;
                        r_head_src  <= seletor;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        r_skid_data <= w_sel_data;
                        r_skid_src  <= seletor;
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_accept && w_pop) begin
                        r_head_data <= w_sel_data;
                        r_head_src  <= seletor;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_head_data <= r_skid_data;
                        r_head_src  <= r_skid_src;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_head_data;
    assign out_src   = r_head_src;
    assign bad_sel   = r_bad_sel;

endmodule

`default_nettype wire

// File: tb/tb_operand_sel_reg.sv
// ============================================================================
// tb_operand_sel_reg
//   Scoreboard bench for operand_sel_reg with NUM_SRC=4 and NUM_SRC=3 instances.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_operand_sel_reg;

    localparam int W  = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [SW-1:0]  seletor   = '0;
    logic [4*W-1:0] src_data  = '0;
    logic           in_valid  = 1'b0;
    logic           flush     = 1'b0;
    logic           out_ready = 1'b0;

    logic           in_ready4, out_valid4, bad4;
    logic [W-1:0]   out_data4;
    logic [SW-1:0]  out_src4;
    logic           in_ready3, out_valid3, bad3;
    logic [W-1:0]   out_data3;
    logic [SW-1:0]  out_src3;

    operand_sel_reg #(.WIDTH(W), .NUM_SRC(4), .SEL_W(SW)) dut4 (
        .clk(clk), .reset(reset), .seletor(seletor), .src_data(src_data),
        .in_valid(in_valid), .in_ready(in_ready4), .flush(flush),
        .out_data(out_data4), .out_src(out_src4), .out_valid(out_valid4),
        .out_ready(out_ready), .bad_sel(bad4)
    );

    operand_sel_reg #(.WIDTH(W), .NUM_SRC(3), .SEL_W(SW)) dut3 (
        .clk(clk), .reset(reset), .seletor(seletor), .src_data(src_data[3*W-1:0]),
        .in_valid(in_valid), .in_ready(in_ready3), .flush(flush),
        .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
        .out_ready(out_ready), .bad_sel(bad3)
    );

    typedef struct {
        logic [SW-1:0] src;
        logic [W-1:0]  d4;
        logic [W-1:0]  d3;
    } beat_t;

    beat_t      q[$];
    beat_t      nb;
    int         occ_now = 0;
    bit         bad_exp = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [W-1:0] src[4];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a FIFO of at most two beats.
    always @(posedge reset) begin
        q.delete();
        bad_exp = 1'b0;
        occ_now = 0;
    end

    // Issue side: records what the stage should have accepted at this edge.
    always @(posedge clk) begin
        if (!reset) begin
            if (flush) begin
                q.delete();
            end else if (in_valid && occ_now < 2) begin
                nb.src = seletor;
                nb.d4  = src_data[int'(seletor)*W +: W];
                nb.d3  = (seletor < 2'd3) ? nb.d4 : '0;
                if (seletor >= 2'd3) bad_exp = 1'b1;
                q.push_back(nb);
            end
        end
    end

    // Monitor: compares presented outputs with the scoreboard head.
    always @(negedge clk) begin
        occ_now = q.size();
        if (!reset) begin
            chk("out_valid4", {31'b0, out_valid4}, {31'b0, occ_now > 0});
            chk("out_valid3", {31'b0, out_valid3}, {31'b0, occ_now > 0});
            chk("in_ready4",  {31'b0, in_ready4},  {31'b0, occ_now < 2});
            chk("in_ready3",  {31'b0, in_ready3},  {31'b0, occ_now < 2});
            chk("bad_sel3",   {31'b0, bad3},       {31'b0, bad_exp});
            chk("bad_sel4",   {31'b0, bad4},       32'd0);
            if (occ_now > 0) begin
                chk("out_data4", out_data4, q[0].d4);
                chk("out_src4",  {30'b0, out_src4}, {30'b0, q[0].src});
                chk("out_data3", out_data3, q[0].d3);
                chk("out_src3",  {30'b0, out_src3}, {30'b0, q[0].src});
                if (out_ready && !flush) void'(q.pop_front());
            end
        end
    end

    task automatic cyc(input bit v, input logic [SW-1:0] s, input bit f, input bit r);
        @(posedge clk);
        #1;
        in_valid  = v;
        seletor   = s;
        flush     = f;
        out_ready = r;
        src_data  = {src[3], src[2], src[1], src[0]};
    endtask

    initial begin
        for (int k = 0; k < 4; k++) src[k] = 32'h1000_0000 + k;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid4}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready4},  32'd1);
        chk("rst_out_data",  out_data4, 32'd0);

        // Back-to-back stream through every source
        for (int k = 0; k < 4; k++) cyc(1'b1, SW'(k), 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);

        // Backpressure: A, B fill the buffer, C waits
        src[0] = 32'hAAAA_0001; src[1] = 32'hBBBB_0002; src[2] = 32'hCCCC_0003;
        cyc(1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk("bp_in_ready", {31'b0, in_ready4}, 32'd0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 2'd0, 1'b0, 1'b1);

        // Out-of-range selector, then flush and more beats
        src[3] = 32'hDDDD_0004;
        cyc(1'b1, 2'd3, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);

        // Async reset while full, without waiting for an edge
        cyc(1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid4}, 32'd0);
        chk("arst_in_ready",  {31'b0, in_ready4},  32'd1);
        chk("arst_out_data",  out_data4, 32'd0);
        chk("arst_bad_sel",   {31'b0, bad3},       32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Flush while full with a beat offered
        cyc(1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 2'd0, 1'b0, 1'b1);

        // Simultaneous accept and pop in ONE
        cyc(1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [SW-1:0] s;
            bit f;
            for (int k = 0; k < 4; k++) src[k] = $urandom;
            s = SW'($urandom_range(0, 3));
            f = ($urandom_range(0, 15) == 0);
            if (f && s == 2'd3) s = 2'd0;
            cyc($urandom_range(0, 3) != 0, s, f, $urandom_range(0, 2) != 0);
        end

        repeat (4) cyc(1'b0, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
